// File: rtl/spi_word_master_if.sv
// Word-level handshake between a command source and spi_word_master.
// The master modport is the command source; the slave modport is the SPI block.
interface spi_word_master_if #(
  parameter int WORD_BITS = 16
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [WORD_BITS-1:0] tx_data;
  logic                 rx_valid;
  logic [WORD_BITS-1:0] rx_data;
  logic                 busy;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  rx_valid,
    input  rx_data,
    input  busy
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output rx_valid,
    output rx_data,
    output busy
  );
endinterface

// File: rtl/spi_word_master.sv
// Mode-0 SPI master: one WORD_BITS frame per chip-select, MSB first, full duplex,
// with a guaranteed CS-high gap of CS_GAP clk cycles between frames.
module spi_word_master #(
  parameter int WORD_BITS = 16,
  parameter int CLK_DIV   = 4,
  parameter int CS_GAP    = 16
) (
  input  logic              clk,
  input  logic              reset,
  spi_word_master_if.slave  word,
  output logic              SPI_CLK,
  output logic              SPI_CS,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * WORD_BITS + 1);
  localparam int GAP_W  = $clog2(CS_GAP + 1);

  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]     DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0]     DIV_ZERO  = DIV_W'(0);
  localparam logic [EDGE_W-1:0]    EDGE_LAST = EDGE_W'(2 * WORD_BITS - 1);
  localparam logic [EDGE_W-1:0]    EDGE_ONE  = EDGE_W'(1);
  localparam logic [EDGE_W-1:0]    EDGE_ZERO = EDGE_W'(0);
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(CS_GAP - 1);
  localparam logic [GAP_W-1:0]     GAP_ONE   = GAP_W'(1);
  localparam logic [GAP_W-1:0]     GAP_ZERO  = GAP_W'(0);
  localparam logic [WORD_BITS-1:0] WORD_ZERO = {WORD_BITS{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [DIV_W-1:0]      div_r, div_s;
  logic [EDGE_W-1:0]     edge_r, edge_s;
  logic [GAP_W-1:0]      gap_r, gap_s;
  logic [WORD_BITS-1:0]  tx_shift_r, tx_shift_s;
  logic [WORD_BITS-1:0]  rx_shift_r, rx_shift_s;
  logic [WORD_BITS-1:0]  rx_data_r, rx_data_s;
  logic                  rx_valid_r, rx_valid_s;
  logic                  sclk_r, sclk_s;
  logic                  cs_r, cs_s;
  logic                  mosi_r, mosi_s;
  logic                  tx_ready_r, tx_ready_s;
  logic                  busy_r, busy_s;

  // Next-state and datapath decode for the frame sequencer
  always_comb begin
    state_s    = state_r;
    div_s      = div_r;
    edge_s     = edge_r;
    gap_s      = gap_r;
    tx_shift_s = tx_shift_r;
    rx_shift_s = rx_shift_r;
    rx_data_s  = rx_data_r;
    rx_valid_s = 1'b0;
    sclk_s     = sclk_r;
    cs_s       = cs_r;
    mosi_s     = mosi_r;

    case (state_r)
      IDLE: begin
        if (word.tx_valid && tx_ready_r) begin
          tx_shift_s = word.tx_data;
          rx_shift_s = WORD_ZERO;
          mosi_s     = word.tx_data[WORD_BITS-1];
          cs_s       = 1'b0;
          sclk_s     = 1'b0;
          div_s      = DIV_ZERO;
          edge_s     = EDGE_ZERO;
          state_s    = SHIFT;
        end else begin
          state_s    = IDLE;
        end
      end

      SHIFT: begin
        if (div_r == DIV_LAST) begin
          div_s  = DIV_ZERO;
          sclk_s = ~sclk_r;
          edge_s = edge_r + EDGE_ONE;
          // The last toggle is always a falling edge, so the final MISO bit is already in.
          if (edge_r == EDGE_LAST) begin
            cs_s       = 1'b1;
            mosi_s     = 1'b0;
            rx_data_s  = rx_shift_r;
            rx_valid_s = 1'b1;
            gap_s      = GAP_ZERO;
            state_s    = GAP;
          end else if (!sclk_r) begin
            rx_shift_s = {rx_shift_r[WORD_BITS-2:0], SPI_MISO};
          end else begin
            tx_shift_s = {tx_shift_r[WORD_BITS-2:0], 1'b0};
            mosi_s     = tx_shift_r[WORD_BITS-2];
          end
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end

      GAP: begin
        if (gap_r == GAP_LAST) begin
          state_s = IDLE;
        end else begin
          gap_s   = gap_r + GAP_ONE;
        end
      end

      default: begin
        state_s = IDLE;
        cs_s    = 1'b1;
        sclk_s  = 1'b0;
        mosi_s  = 1'b0;
      end
    endcase

    tx_ready_s = (state_s == IDLE);
    busy_s     = (state_s != IDLE);
  end

  // State and output registers; reset drops CS and idles the bus immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      div_r      <= DIV_ZERO;
      edge_r     <= EDGE_ZERO;
      gap_r      <= GAP_ZERO;
      tx_shift_r <= WORD_ZERO;
      rx_shift_r <= WORD_ZERO;
      rx_data_r  <= WORD_ZERO;
      rx_valid_r <= 1'b0;
      sclk_r     <= 1'b0;
      cs_r       <= 1'b1;
      mosi_r     <= 1'b0;
      tx_ready_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_r      <= div_s;
      edge_r     <= edge_s;
      gap_r      <= gap_s;
      tx_shift_r <= tx_shift_s;
      rx_shift_r <= rx_shift_s;
      rx_data_r  <= rx_data_s;
      rx_valid_r <= rx_valid_s;
      sclk_r     <= sclk_s;
      cs_r       <= cs_s;
      mosi_r     <= mosi_s;
      tx_ready_r <= tx_ready_s;
      busy_r     <= busy_s;
    end
  end

  assign word.tx_ready = tx_ready_r;
  assign word.rx_valid = rx_valid_r;
  assign word.rx_data  = rx_data_r;
  assign word.busy     = busy_r;
  assign SPI_CLK       = sclk_r;
  assign SPI_CS        = cs_r;
  assign SPI_MOSI      = mosi_r;

endmodule
